pipelined_addsub: RTL and testbench

- Parametrised pipelined carry-chain adder/subtractor, the successor to the fixed 32-bit, 4×8-bit chunked adder.
- The operand is split into NUM_CHUNKS chunks of CHUNK_W bits. One chunk is resolved per pipeline stage, with a registered carry between stages.
- Input skew and output de-skew are internal, so operands enter and results leave word-aligned.
- Adds a valid/ready handshake with backpressure, add/sub mode, carry-out and signed overflow. Used in datapath blocks needing wide adds at full clock rate.

---
 rtl/pipelined_addsub.sv | 120 ++++++++++++
 tb/tb_pipelined_addsub.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-chunk adder/subtractor: one CHUNK_W slice of the sum per stage,
// with operand skew and result de-skew kept internal so words enter and leave aligned.
module pipelined_addsub #(
  parameter int WIDTH   = 32,
  parameter int CHUNK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK_W;

  // A held result stalls every stage at once, so one enable covers the pipe.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  function automatic logic [CHUNK_W:0] chunk_add(input logic [CHUNK_W-1:0] x,
                                                 input logic [CHUNK_W-1:0] y,
                                                 input logic               c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK_W{1'b0}}, c};
  endfunction

  // The carry into the MSB is recovered from the MSB sum bit and its operand bits.
  function automatic logic signed_ovf(input logic signed [0:0] x_msb,
                                      input logic signed [0:0] y_msb,
                                      input logic signed [0:0] s_msb,
                                      input logic              c_out);
    return (x_msb[0] ^ y_msb[0] ^ s_msb[0]) ^ c_out;
  endfunction

  for (genvar s = 0; s < NUM_CHUNKS; s++) begin : g_st
    localparam int DONE = s * CHUNK_W;
    localparam int LEFT = WIDTH - DONE;

    logic [LEFT-1:0]         opa;
    logic [LEFT-1:0]         opb;
    logic                    cin;
    logic                    vin;
    logic [CHUNK_W:0]        csum;
    logic [DONE+CHUNK_W-1:0] res_d;
    logic [DONE+CHUNK_W-1:0] res_p;
    logic                    car_p;
    logic                    vld_p;

    // Stage 0 boundary: operand conditioning at accept
    if (s == 0) begin : g_head
      assign opa   = a;
      assign opb   = sub ? ~b : b;
      assign cin   = sub ? ~ci : ci;
      assign vin   = in_valid;
      assign res_d = csum[CHUNK_W-1:0];
    end else begin : g_body
      assign opa   = g_st[s-1].g_skew.a_p;
      assign opb   = g_st[s-1].g_skew.b_p;
      assign cin   = g_st[s-1].car_p;
      assign vin   = g_st[s-1].vld_p;
      assign res_d = {csum[CHUNK_W-1:0], g_st[s-1].res_p};
    end

    assign csum = chunk_add(opa[CHUNK_W-1:0], opb[CHUNK_W-1:0], cin);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        car_p <= 1'b0;
        res_p <= '0;
      end else if (adv) begin
        vld_p <= vin;
        car_p <= csum[CHUNK_W];
        res_p <= res_d;
      end
    end

    // Upper, not-yet-resolved operand chunks ride along until their stage.
    if (s < NUM_CHUNKS - 1) begin : g_skew
      logic [LEFT-CHUNK_W-1:0] a_p;
      logic [LEFT-CHUNK_W-1:0] b_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_p <= '0;
          b_p <= '0;
        end else if (adv) begin
          a_p <= opa[LEFT-1:CHUNK_W];
          b_p <= opb[LEFT-1:CHUNK_W];
        end
      end
    end else begin : g_tail
      logic ovf_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_p <= 1'b0;
        end else if (adv) begin
          ovf_p <= signed_ovf(opa[CHUNK_W-1], opb[CHUNK_W-1],
                              csum[CHUNK_W-1], csum[CHUNK_W]);
        end
      end
    end
  end

  // Output boundary: last stage holds the full de-skewed word
  assign out_valid = g_st[NUM_CHUNKS-1].vld_p;
  assign sum       = g_st[NUM_CHUNKS-1].res_p;
  assign co        = g_st[NUM_CHUNKS-1].car_p;
  assign ovf       = g_st[NUM_CHUNKS-1].g_tail.ovf_p;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three configurations share one stimulus bus, each with
// its own scoreboard fed from an arithmetic reference model.
module tb_pipelined_addsub;

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ovf;
    int          acc;
    int          st;
  } exp_t;

  localparam int NCFG = 3;
  localparam int WS[NCFG] = '{32, 64, 16};
  localparam int CS[NCFG] = '{8, 16, 16};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        ci;
  logic        sub;
  logic        out_ready;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  bit          armed = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = WS[g];
    localparam int C = CS[g];
    localparam int L = W / C;

    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    exp_t         q[$];
    int           stalls = 0;
    bit           prev_stall = 1'b0;

    pipelined_addsub #(.WIDTH(W), .CHUNK_W(C)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a[W-1:0]),
      .b        (b[W-1:0]),
      .ci       (ci),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .co       (co),
      .ovf      (ovf)
    );

    // Reference: exact integer add/sub, carry = bit W, overflow = signed result out of range.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tci, input logic tsub);
      exp_t           e;
      logic [W:0]     u;
      logic [W+1:0]   sr;
      logic [W+1:0]   xa;
      logic [W+1:0]   xb;
      logic [W+1:0]   xc;
      xa = {{2{ta[W-1]}}, ta};
      xb = {{2{tb[W-1]}}, tb};
      xc = {{(W+1){1'b0}}, tci};
      if (!tsub) begin
        u    = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tci};
        e.co = u[W];
        sr   = xa + xb + xc;
      end else begin
        u    = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tci};
        e.co = !u[W];
        sr   = xa - xb - xc;
      end
      e.sum = 64'(u[W-1:0]);
      e.ovf = (sr != {{2{sr[W-1]}}, sr[W-1:0]});
      e.acc = 0;
      e.st  = 0;
      return e;
    endfunction

    always @(negedge rst_n) begin
      if (armed) begin
        #1;
        check($sformatf("cfg%0d_reset_now_out_valid", g), 80'(out_valid), 80'(0));
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
        q.delete();
        prev_stall = 1'b0;
        check($sformatf("cfg%0d_reset_state", g), 80'({out_valid, co, ovf, sum}), 80'(0));
      end else begin
        check($sformatf("cfg%0d_in_ready", g), 80'(in_ready), 80'(!(out_valid && !out_ready)));
        if (out_valid) begin
          if (q.size() == 0) begin
            check($sformatf("cfg%0d_spurious_result", g), 80'(out_valid), 80'(0));
          end else begin
            e = q[0];
            if (!prev_stall)
              check($sformatf("cfg%0d_latency", g), 80'(cyc - e.acc - (stalls - e.st)), 80'(L));
            check($sformatf("cfg%0d_sum", g), 80'(sum), 80'(e.sum[W-1:0]));
            check($sformatf("cfg%0d_co_ovf", g), 80'({co, ovf}), 80'({e.co, e.ovf}));
            if (out_ready) void'(q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        if (prev_stall) stalls++;
        if (in_valid && in_ready) begin
          e     = model(a[W-1:0], b[W-1:0], ci, sub);
          e.acc = cyc;
          e.st  = stalls;
          q.push_back(e);
        end
      end
    end
  end

  // Present one word, hold it until the 32/8 instance accepts it.
  task automatic drive(input logic [63:0] ta, input logic [63:0] tb,
                       input logic tci, input logic tsub);
    bit r;
    int n;
    n = 0;
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
    do begin
      r = g_cfg[0].in_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 200);
    if (!r) check("drive_timeout", 80'(r), 80'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic directed(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tci, input logic tsub,
                          input logic [31:0] xs, input logic xco, input logic xovf);
    int n;
    drive({32'h0, ta}, {32'h0, tb}, tci, tsub);
    in_valid = 1'b0;
    n = 0;
    while (!g_cfg[0].out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_wait"}, 80'(n), 80'(3));
    check({tag, "_sum"}, 80'(g_cfg[0].sum), 80'(xs));
    check({tag, "_co"}, 80'(g_cfg[0].co), 80'(xco));
    check({tag, "_ovf"}, 80'(g_cfg[0].ovf), 80'(xovf));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    armed = 1'b1;

    directed("add_ff_1",     32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    directed("ripple_all",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("add_posovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("sub_5_7",      32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_min_1",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    idle(6);

    for (int i = 0; i < 100; i++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), i[0]);
      check("stream_in_ready", 80'(g_cfg[0].in_ready), 80'(1));
    end
    idle(6);

    fork
      begin
        for (int i = 0; i < 30; i++)
          drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        repeat (12) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (5) begin
          #1 check("hold_in_ready", 80'(g_cfg[0].in_ready), 80'(0));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(8);

    for (int i = 0; i < 3; i++)
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 5; i++)
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    idle(10);

    check("cfg0_drained", 80'(g_cfg[0].q.size()), 80'(0));
    check("cfg1_drained", 80'(g_cfg[1].q.size()), 80'(0));
    check("cfg2_drained", 80'(g_cfg[2].q.size()), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
